// File: rtl/alu_op_issuer.sv
// Issues one command at a time to a combinational ALU and returns the result on a valid/ready channel.
// Latency: accept at edge N gives rsp_valid from edge N+ALU_LAT. req_ready is low from accept until the response is consumed.
// ALU_ISSUER_FLAGS_EN adds the registered outputs rsp_zero and rsp_neg.
module alu_op_issuer #(
  parameter int WIDTH   = 32,
  parameter int ALU_LAT = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [2:0]       rsp_op,
  output logic [2:0]       alu_op_code,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_y,
`ifdef ALU_ISSUER_FLAGS_EN
  output logic             rsp_zero,
  output logic             rsp_neg,
`endif
  output logic [CNT_W-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_e;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_e           state_q, state_d;
  logic [3:0]       wait_q, wait_d;
  logic [2:0]       alu_op_q, alu_op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
  logic [2:0]       rsp_op_q, rsp_op_d;
  logic [CNT_W-1:0] op_count_q, op_count_d;
`ifdef ALU_ISSUER_FLAGS_EN
  logic             zero_q, zero_d;
  logic             neg_q, neg_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wait_q     <= '0;
      alu_op_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_y_q    <= '0;
      rsp_op_q   <= '0;
      op_count_q <= '0;
`ifdef ALU_ISSUER_FLAGS_EN
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      wait_q     <= wait_d;
      alu_op_q   <= alu_op_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_y_q    <= rsp_y_d;
      rsp_op_q   <= rsp_op_d;
      op_count_q <= op_count_d;
`ifdef ALU_ISSUER_FLAGS_EN
      zero_q     <= zero_d;
      neg_q      <= neg_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    alu_op_d   = alu_op_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_y_d    = rsp_y_q;
    rsp_op_d   = rsp_op_q;
    op_count_d = op_count_q;
`ifdef ALU_ISSUER_FLAGS_EN
    zero_d     = zero_q;
    neg_d      = neg_q;
`endif
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          alu_op_d = req_op;
          alu_a_d  = req_a;
          alu_b_d  = req_b;
          wait_d   = LAT_M1;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        // alu_* stay registered, so the ALU inputs are stable for the whole wait
        if (wait_q == 4'd0) begin
          rsp_y_d  = alu_y;
          rsp_op_d = alu_op_q;
`ifdef ALU_ISSUER_FLAGS_EN
          zero_d   = (alu_y == '0);
          neg_d    = alu_y[WIDTH-1];
`endif
          state_d  = RESP;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          op_count_d = op_count_q + CNT_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready   = (state_q == IDLE);
  assign rsp_valid   = (state_q == RESP);
  assign rsp_y       = rsp_y_q;
  assign rsp_op      = rsp_op_q;
  assign alu_op_code = alu_op_q;
  assign alu_a       = alu_a_q;
  assign alu_b       = alu_b_q;
  assign op_count    = op_count_q;
`ifdef ALU_ISSUER_FLAGS_EN
  assign rsp_zero    = zero_q;
  assign rsp_neg     = neg_q;
`endif

endmodule

// File: tb/tb_alu_op_issuer.sv
// Directed bench for alu_op_issuer: three instances (ALU_LAT=1, ALU_LAT=3, CNT_W=4), each driving a behavioural ALU.
module tb_alu_op_issuer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  req_valid = '0;
  logic        rsp_ready = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_a = '0;
  logic [31:0] req_b = '0;

  logic        req_ready_w [3];
  logic        rsp_valid_w [3];
  logic [31:0] rsp_y_w [3];
  logic [2:0]  rsp_op_w [3];
  logic [2:0]  alu_op_w [3];
  logic [31:0] alu_a_w [3];
  logic [31:0] alu_b_w [3];
  logic [31:0] alu_y_w [3];
  logic [15:0] cnt_w [3];
  logic [15:0] cnt1, cnt3;
  logic [3:0]  cnt4;
`ifdef ALU_ISSUER_FLAGS_EN
  logic        zero_w [3];
  logic        neg_w [3];
`endif

  int errors = 0;
  int checks = 0;
  logic [15:0] exp_cnt [3];
  logic [15:0] cnt_mask [3];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a;
      3'b001:  return a + b;
      3'b010:  return a - b;
      3'b011:  return a & b;
      3'b100:  return a | b;
      3'b101:  return a + 32'd1;
      3'b110:  return a - 32'd1;
      default: return b;
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_alu
    assign alu_y_w[g] = alu_f(alu_op_w[g], alu_a_w[g], alu_b_w[g]);
  end
  assign cnt_w[0] = cnt1;
  assign cnt_w[1] = cnt3;
  assign cnt_w[2] = {12'd0, cnt4};

  alu_op_issuer #(.WIDTH(32), .ALU_LAT(1), .CNT_W(16)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready_w[0]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_w[0]),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y_w[0]), .rsp_op(rsp_op_w[0]),
    .alu_op_code(alu_op_w[0]), .alu_a(alu_a_w[0]), .alu_b(alu_b_w[0]), .alu_y(alu_y_w[0]),
`ifdef ALU_ISSUER_FLAGS_EN
    .rsp_zero(zero_w[0]), .rsp_neg(neg_w[0]),
`endif
    .op_count(cnt1));

  alu_op_issuer #(.WIDTH(32), .ALU_LAT(3), .CNT_W(16)) u_lat3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready_w[1]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_w[1]),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y_w[1]), .rsp_op(rsp_op_w[1]),
    .alu_op_code(alu_op_w[1]), .alu_a(alu_a_w[1]), .alu_b(alu_b_w[1]), .alu_y(alu_y_w[1]),
`ifdef ALU_ISSUER_FLAGS_EN
    .rsp_zero(zero_w[1]), .rsp_neg(neg_w[1]),
`endif
    .op_count(cnt3));

  alu_op_issuer #(.WIDTH(32), .ALU_LAT(1), .CNT_W(4)) u_cnt4 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid[2]), .req_ready(req_ready_w[2]),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .rsp_valid(rsp_valid_w[2]),
    .rsp_ready(rsp_ready), .rsp_y(rsp_y_w[2]), .rsp_op(rsp_op_w[2]),
    .alu_op_code(alu_op_w[2]), .alu_a(alu_a_w[2]), .alu_b(alu_b_w[2]), .alu_y(alu_y_w[2]),
`ifdef ALU_ISSUER_FLAGS_EN
    .rsp_zero(zero_w[2]), .rsp_neg(neg_w[2]),
`endif
    .op_count(cnt4));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Called at a negedge; returns at a negedge right after the response is consumed.
  task automatic run_op(input int s, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input int hold);
    int k;
    check("req_ready_idle", 32'(req_ready_w[s]), 32'd1);
    req_op = op; req_a = a; req_b = b; req_valid[s] = 1'b1;
    @(negedge clk);
    // Scramble the request bus: the issuer must not depend on it after accept.
    req_valid[s] = 1'b0; req_op = ~op; req_a = ~a; req_b = ~b;
    k = 0;
    while (!rsp_valid_w[s] && k < 20) begin
      check("alu_hold", 32'(alu_op_w[s] == op && alu_a_w[s] == a && alu_b_w[s] == b), 32'd1);
      check("req_ready_busy", 32'(req_ready_w[s]), 32'd0);
      @(negedge clk);
      k++;
    end
    check("latency", 32'(k), 32'(lat));
    check("alu_hold_at_rsp", 32'(alu_op_w[s] == op && alu_a_w[s] == a && alu_b_w[s] == b), 32'd1);
    check("rsp_y", rsp_y_w[s], exp);
    check("rsp_op", 32'(rsp_op_w[s]), 32'(op));
`ifdef ALU_ISSUER_FLAGS_EN
    check("rsp_zero", 32'(zero_w[s]), 32'(exp == 32'd0));
    check("rsp_neg", 32'(neg_w[s]), 32'(exp[31]));
`endif
    for (int h = 0; h < hold; h++) begin
      req_valid[s] = 1'b1; req_op = 3'b111; req_a = 32'h5555_5555; req_b = 32'hAAAA_AAAA;
      @(negedge clk);
      check("rsp_y_held", rsp_y_w[s], exp);
      check("rsp_valid_held", 32'(rsp_valid_w[s]), 32'd1);
      check("req_ready_held_low", 32'(req_ready_w[s]), 32'd0);
    end
    req_valid[s] = 1'b0;
    if (hold > 0) check("no_second_accept", 32'(alu_a_w[s] == a && alu_op_w[s] == op), 32'd1);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    exp_cnt[s] = (exp_cnt[s] + 16'd1) & cnt_mask[s];
    check("rsp_valid_clear", 32'(rsp_valid_w[s]), 32'd0);
    check("req_ready_back", 32'(req_ready_w[s]), 32'd1);
    check("op_count", 32'(cnt_w[s]), 32'(exp_cnt[s]));
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] y;
  } vec_t;

  initial begin
    vec_t vecs [9];
    logic [2:0]  op6;
    logic [31:0] a6, b6;

    vecs[0] = '{3'b001, 32'h0000_0005, 32'h0000_0003, 32'h0000_0008};
    vecs[1] = '{3'b001, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000};
    vecs[2] = '{3'b110, 32'h0000_0000, 32'h1234_0000, 32'hFFFF_FFFF};
    vecs[3] = '{3'b000, 32'h1234_5678, 32'h0BAD_0BAD, 32'h1234_5678};
    vecs[4] = '{3'b010, 32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE};
    vecs[5] = '{3'b100, 32'hF0F0_F0F0, 32'h0F0F_0F00, 32'hFFFF_FFF0};
    vecs[6] = '{3'b101, 32'h7FFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{3'b111, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[8] = '{3'b011, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000};

    cnt_mask[0] = 16'hFFFF; cnt_mask[1] = 16'hFFFF; cnt_mask[2] = 16'h000F;
    for (int i = 0; i < 3; i++) exp_cnt[i] = 16'd0;

    // Reset state
    #12;
    check("rst_req_ready", 32'(req_ready_w[0]), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid_w[0]), 32'd0);
    check("rst_rsp_y", rsp_y_w[0], 32'd0);
    check("rst_rsp_op", 32'(rsp_op_w[0]), 32'd0);
    check("rst_alu", 32'(alu_op_w[0] == 3'd0 && alu_a_w[0] == 32'd0 && alu_b_w[0] == 32'd0), 32'd1);
    check("rst_op_count", 32'(cnt_w[0]), 32'd0);
`ifdef ALU_ISSUER_FLAGS_EN
    check("rst_flags", 32'({zero_w[0], neg_w[0]}), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven operations on the ALU_LAT=1 instance, back to back.
    for (int i = 0; i < 8; i++)
      run_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].y, 1, 0);

    // Response held off for 5 cycles while a second command is offered.
    run_op(0, vecs[8].op, vecs[8].a, vecs[8].b, vecs[8].y, 1, 5);
    check("op_count_after_table", 32'(cnt_w[0]), 32'd9);

    // ALU_LAT=3: 10 - 3.
    run_op(1, 3'b010, 32'd10, 32'd3, 32'd7, 3, 0);
    check("lat3_op_count", 32'(cnt_w[1]), 32'd1);

    // Reset while the ALU_LAT=3 instance sits in ISSUE.
    req_op = 3'b001; req_a = 32'h0000_0100; req_b = 32'h0000_0001; req_valid[1] = 1'b1;
    @(negedge clk);
    req_valid[1] = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 32'(req_ready_w[1]), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_rsp_valid", 32'(rsp_valid_w[1]), 32'd0);
    check("mid_rst_alu", 32'(alu_op_w[1] == 3'd0 && alu_a_w[1] == 32'd0 && alu_b_w[1] == 32'd0), 32'd1);
    check("mid_rst_op_count", 32'(cnt_w[1]), 32'd0);
    check("mid_rst_op_count_lat1", 32'(cnt_w[0]), 32'd0);
    for (int i = 0; i < 3; i++) exp_cnt[i] = 16'd0;
    @(negedge clk);
    rst_n = 1'b1;
    check("post_rst_req_ready", 32'(req_ready_w[1]), 32'd1);
    // rsp_ready high with nothing pending must be harmless; no stale response may appear.
    rsp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_rsp", 32'(rsp_valid_w[1]), 32'd0);
    end
    check("idle_rsp_ready_count", 32'(cnt_w[1]), 32'd0);
    rsp_ready = 1'b0;
    @(negedge clk);

    // CNT_W=4: 17 ops cycling all opcodes, counter wraps 15 -> 0 and ends at 1.
    for (int i = 0; i < 17; i++) begin
      op6 = 3'(i % 8);
      a6 = $urandom;
      b6 = $urandom;
      run_op(2, op6, a6, b6, alu_f(op6, a6, b6), 1, 0);
      if (i == 15) check("cnt4_wrap_zero", 32'(cnt_w[2]), 32'd0);
    end
    check("cnt4_final", 32'(cnt_w[2]), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
